// File: rtl/layer_pkg.sv
`default_nettype none
// layer_pkg: shared state encoding and counter-width helper for layer_serializer.
// Rev 1.0
package layer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic int cnt_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/layer_serializer.sv
`default_nettype none
// layer_serializer: gathers one layer's per-neuron results, then streams them one word per cycle.
// Rev 1.0
module layer_serializer
   import layer_pkg::*;
#(
   parameter int NN        = 30,
   parameter int dataWidth = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NN-1:0]           o_valid,
   input  logic [NN*dataWidth-1:0] x_out,
   output logic [dataWidth-1:0]    data_out,
   output logic                    data_valid,
   output logic                    busy,
   output logic                    layer_done,
   output logic                    overrun
);

   localparam int            CW     = cnt_w(NN);
   localparam logic [CW-1:0] c_LAST = CW'(NN - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [NN-1:0]          r_mask;
   logic [CW-1:0]          r_count;
   logic [dataWidth-1:0]   r_buf [NN];
   logic                   w_full;
   logic                   w_last;

   // The words arriving in the completing cycle count toward a full mask.
   assign w_full = &(r_mask | o_valid);

   always_comb begin
      w_state_nxt = r_state;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_full) begin
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            w_last = (r_count == c_LAST);
            if (w_last) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_mask     <= '0;
         r_count    <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         layer_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         busy       <= (w_state_nxt == SHIFT);
         data_out   <= '0;
         data_valid <= 1'b0;
         layer_done <= 1'b0;
         if (r_state == IDLE) begin
            r_mask  <= w_full ? '0 : (r_mask | o_valid);
            r_count <= '0;
         end else begin
            data_out   <= r_buf[r_count];
            data_valid <= 1'b1;
            layer_done <= w_last;
            r_count    <= w_last ? '0 : r_count + CW'(1);
            // No backpressure upstream: results landing mid-burst are dropped and flagged.
            if (|o_valid) begin
               overrun <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NN; i++) begin
         if ((r_state == IDLE) && o_valid[i]) begin
            r_buf[i] <= x_out[i*dataWidth +: dataWidth];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_layer_serializer.sv
`default_nettype none
// tb_layer_serializer: randomized scoreboard bench for layer_serializer (NN=4) plus an NN=1 build.
// Rev 1.0
module tb_layer_serializer;

   localparam int NN  = 4;
   localparam int DW  = 16;
   localparam int INF = 1 << 30;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NN-1:0]     ov  = '0;
   logic [NN*DW-1:0]  xo  = '0;
   logic [DW-1:0]     data_out;
   logic              data_valid, busy, layer_done, overrun;

   logic [0:0]        ov1 = '0;
   logic [DW-1:0]     x1  = '0;
   logic [DW-1:0]     data_out1;
   logic              data_valid1, busy1, layer_done1, overrun1;

   layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
      .clk(clk), .rst(rst), .o_valid(ov), .x_out(xo),
      .data_out(data_out), .data_valid(data_valid), .busy(busy),
      .layer_done(layer_done), .overrun(overrun)
   );

   layer_serializer #(.NN(1), .dataWidth(DW)) dut1 (
      .clk(clk), .rst(rst), .o_valid(ov1), .x_out(x1),
      .data_out(data_out1), .data_valid(data_valid1), .busy(busy1),
      .layer_done(layer_done1), .overrun(overrun1)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   typedef struct {
      logic [DW-1:0] d;
      logic          last;
      int            e;
   } exp_t;

   exp_t          q[$];
   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] mbuf [NN];
   logic [NN-1:0] mmask    = '0;
   int            sh       = -1000;
   int            ovr_edge = INF;
   bit            mon_en   = 1'b0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_cnt);
      end
   endtask

   // Reference model: a burst starts one edge after the mask fills and occupies NN edges.
   task automatic drive(input logic [NN-1:0] v, input logic [NN*DW-1:0] x);
      int s;
      @(posedge clk);
      #1;
      ov = v;
      xo = x;
      s  = edge_cnt + 1;
      if ((v != '0) && (s >= sh + 1) && (s <= sh + NN)) begin
         if (s < ovr_edge) ovr_edge = s;
      end else begin
         for (int i = 0; i < NN; i++) if (v[i]) mbuf[i] = x[i*DW +: DW];
         mmask = mmask | v;
         if (&mmask) begin
            for (int k = 0; k < NN; k++) q.push_back('{mbuf[k], (k == NN - 1), s + 1 + k});
            sh    = s;
            mmask = '0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive('0, '0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      ov  = '0;
      xo  = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      mmask    = '0;
      sh       = -1000;
      ovr_edge = INF;
   endtask

   function automatic logic [NN*DW-1:0] pack4(input logic [DW-1:0] w3, w2, w1, w0);
      return {w3, w2, w1, w0};
   endfunction

   always @(negedge clk) begin
      exp_t e;
      bit   eb;
      if (mon_en) begin
         eb = (edge_cnt >= sh) && (edge_cnt <= sh + NN - 1);
         chk(busy == eb, "busy", 64'(busy), 64'(eb));
         chk(overrun == (edge_cnt >= ovr_edge), "overrun", 64'(overrun), 64'(edge_cnt >= ovr_edge));
         if (data_valid) begin
            if (q.size() == 0) begin
               chk(1'b0, "unexpected_word", 64'(data_out), 64'(0));
            end else begin
               e = q.pop_front();
               chk(e.e == edge_cnt, "word_time", 64'(edge_cnt), 64'(e.e));
               chk(data_out == e.d, "data_out", 64'(data_out), 64'(e.d));
               chk(layer_done == e.last, "layer_done", 64'(layer_done), 64'(e.last));
            end
         end else begin
            if ((q.size() > 0) && (q[0].e <= edge_cnt)) begin
               e = q.pop_front();
               chk(1'b0, "missing_word", 64'(edge_cnt), 64'(e.e));
            end
            chk(data_out == '0, "idle_data_out", 64'(data_out), 64'(0));
            chk(layer_done == 1'b0, "idle_layer_done", 64'(layer_done), 64'(0));
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk({data_out, data_valid, busy, layer_done, overrun} == '0, "reset_outputs",
          64'({data_out, data_valid, busy, layer_done, overrun}), 64'(0));
      chk({data_out1, data_valid1, busy1, layer_done1, overrun1} == '0, "reset_outputs_nn1",
          64'({data_out1, data_valid1, busy1, layer_done1, overrun1}), 64'(0));
      mon_en = 1'b1;

      // Simultaneous capture
      drive(4'hF, pack4(16'h0004, 16'h0003, 16'h0002, 16'h0001));
      idle(6);

      // Staggered capture: bits 0,2,1,3 on cycles 0,3,5,9
      drive(4'b0001, pack4(0, 0, 0, 16'h0011));
      idle(2);
      drive(4'b0100, pack4(0, 16'h0033, 0, 0));
      idle(1);
      drive(4'b0010, pack4(0, 0, 16'h0022, 0));
      idle(3);
      drive(4'b1000, pack4(16'h0044, 0, 0, 0));
      idle(6);

      // Repeat valid on neuron 1: latest value wins
      drive(4'b0010, pack4(0, 0, 16'hAAAA, 0));
      idle(1);
      drive(4'b0010, pack4(0, 0, 16'hBBBB, 0));
      drive(4'b1101, pack4(16'h0C0C, 16'h0B0B, 0, 16'h0A0A));
      idle(6);

      // Overrun during the second burst word, then recovery
      drive(4'hF, pack4(16'h1004, 16'h1003, 16'h1002, 16'h1001));
      idle(1);
      drive(4'b0100, pack4(0, 16'hDEAD, 0, 0));
      idle(5);
      drive(4'hF, pack4(16'h2004, 16'h2003, 16'h2002, 16'h2001));
      idle(6);

      // Reset mid-burst, then a clean burst
      drive(4'hF, pack4(16'h3004, 16'h3003, 16'h3002, 16'h3001));
      idle(2);
      do_reset();
      chk({data_valid, busy, overrun, layer_done} == '0, "post_reset",
          64'({data_valid, busy, overrun, layer_done}), 64'(0));
      drive(4'hF, pack4(16'h4004, 16'h4003, 16'h4002, 16'h4001));
      idle(6);

      // Randomized traffic with occasional mid-stream resets
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 2) == 0) begin
            drive(NN'($urandom), {$urandom, $urandom});
         end else begin
            drive('0, {$urandom, $urandom});
         end
      end
      idle(2);

      for (int c = 0; c < 20 && q.size() != 0; c++) idle(1);
      chk(q.size() == 0, "drain_timeout", 64'(q.size()), 64'(0));
      idle(2);

      // NN=1 build: single-word burst with layer_done in the same cycle
      @(posedge clk);
      #1;
      ov1 = 1'b1;
      x1  = 16'h7FFF;
      @(posedge clk);
      #1;
      ov1 = 1'b0;
      x1  = '0;
      @(negedge clk);
      chk(data_valid1 == 1'b0 && busy1 == 1'b1, "nn1_enter", 64'({data_valid1, busy1}), 64'(2'b01));
      @(negedge clk);
      chk(data_valid1 && layer_done1 && data_out1 == 16'h7FFF, "nn1_word",
          64'({data_valid1, layer_done1, data_out1}), 64'({2'b11, 16'h7FFF}));
      @(negedge clk);
      chk({data_valid1, layer_done1, busy1, overrun1, data_out1} == '0, "nn1_after",
          64'({data_valid1, layer_done1, busy1, overrun1, data_out1}), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
